// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator.
// Consumes note-on/note-off strobes from the note parser and produces a
// registered amplitude level that steps once per sample_tick.
// The note index is latched on each accepted trigger, so the oscillator keeps
// its pitch through release.
// Optional build macro HARD_RETRIG_EN: a retrigger also zeroes the level, so
// every attack starts from silence.
module adsr_envelope #(
    parameter int               ENV_W   = 16,
    parameter logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}}
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                noteTrig,
    input  logic                noteOff,
    input  logic signed [31:0]  noteIdx,
    input  logic                sample_tick,
    input  logic [ENV_W-1:0]    atk_step,
    input  logic [ENV_W-1:0]    dec_step,
    input  logic [ENV_W-1:0]    sus_lvl,
    input  logic [ENV_W-1:0]    rel_step,
    output logic [ENV_W-1:0]    env_level,
    output logic [2:0]          env_state,
    output logic                env_active,
    output logic                env_done,
    output logic signed [31:0]  note_idx_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    env_state_t         state_q, state_d;
    logic [ENV_W-1:0]   level_q, level_d;
    logic signed [31:0] idx_q, idx_d;
    logic               done_q, done_d;
    logic               active_q;

    // Segment end tests use one extra bit so that level+step cannot wrap.
    logic [ENV_W:0]     atk_sum;
    logic [ENV_W:0]     dec_floor;

    assign atk_sum   = {1'b0, level_q} + {1'b0, atk_step};
    assign dec_floor = {1'b0, sus_lvl} + {1'b0, dec_step};

    // Next-state and next-level logic; the event priority is trigger > off > tick.
    always_comb begin
        // NOTE: every variable gets a default here so that no path infers a latch.
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        if (noteTrig) begin
            state_d = ATTACK;
            idx_d   = noteIdx;
`ifdef HARD_RETRIG_EN
            level_d = '0;
`else
            level_d = level_q;
`endif
        end else if (noteOff) begin
            if (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)
                state_d = RELEASE;
        end else if (sample_tick) begin
            case (state_q)
                ATTACK: begin
                    if (atk_step == '0 || atk_sum >= {1'b0, ENV_MAX}) begin
                        level_d = ENV_MAX;
                        state_d = DECAY;
                    end else begin
                        level_d = atk_sum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    // A level already at or below sustain on entry snaps to it here.
                    if (dec_step == '0 || {1'b0, level_q} <= dec_floor) begin
                        level_d = sus_lvl;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = level_q - dec_step;
                    end
                end
                SUSTAIN: level_d = sus_lvl;
                RELEASE: begin
                    if (rel_step == '0 || level_q <= rel_step) begin
                        level_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        level_d = level_q - rel_step;
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (Reset) begin
            state_q  <= IDLE;
            level_q  <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            active_q <= (state_d != IDLE);
        end
    end

    assign env_level    = level_q;
    assign env_state    = state_q;
    assign env_active   = active_q;
    assign env_done     = done_q;
    assign note_idx_out = idx_q;

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-voice ADSR envelope generator directly downstream of the keyboard note parser.
- Consumes the parser's one-cycle noteTrig/noteOff strobes and its note index.
- Produces a registered amplitude level that steps once per sample-rate strobe. The level feeds the voice amplifier/mixer.
- Latches the note index on each trigger so the oscillator holds pitch through release.

Parameters:
ENV_W, 16, width of envelope level, step and sustain values (unsigned)
ENV_MAX, 2**ENV_W-1, peak level reached at end of attack

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
noteTrig  in  1  one-cycle note-on strobe from parser
noteOff  in  1  one-cycle note-off strobe from parser
noteIdx  in  32  signed note index from parser (int)
sample_tick  in  1  one-cycle sample-rate strobe; envelope advances only on it
atk_step  in  ENV_W  level increment per tick in ATTACK
dec_step  in  ENV_W  level decrement per tick in DECAY
sus_lvl  in  ENV_W  sustain level
rel_step  in  ENV_W  level decrement per tick in RELEASE
env_level  out  ENV_W  current envelope amplitude
env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
env_active  out  1  high when env_state != IDLE
env_done  out  1  one-cycle pulse on RELEASE->IDLE
note_idx_out  out  32  noteIdx latched at last accepted noteTrig

Behaviour:
- One clock, Clk. Reset is synchronous, active-high.
- All outputs are registered.
- Reset values: env_level=0, env_state=IDLE, env_active=0, env_done=0, note_idx_out=0. Reset mid-envelope returns to these on the next edge with no done pulse.
- Event priority per cycle: Reset > noteTrig > noteOff > sample_tick. A cycle carrying an event ignores sample_tick for stepping.
- noteTrig, any state: next state ATTACK; note_idx_out<=noteIdx; env_level unchanged (attack resumes from current level, no click).
- noteOff in ATTACK/DECAY/SUSTAIN: next state RELEASE; level unchanged. noteOff in IDLE/RELEASE: ignored.
- noteTrig and noteOff in the same cycle: trigger wins.
- Stepping occurs only on sample_tick. Arithmetic is done at ENV_W+1 bits to avoid wrap.
  - ATTACK: if atk_step==0 or level+atk_step>=ENV_MAX then level<=ENV_MAX, state<=DECAY; else level+=atk_step.
  - DECAY: if dec_step==0 or level<=sus_lvl+dec_step then level<=sus_lvl, state<=SUSTAIN; else level-=dec_step.
    - If level is already <= sus_lvl on entry, the first tick snaps level to sus_lvl.
  - SUSTAIN: level<=sus_lvl each tick; tracks live changes to sus_lvl.
  - RELEASE: if rel_step==0 or level<=rel_step then level<=0, state<=IDLE, env_done=1 for one cycle; else level-=rel_step.
  - IDLE: level held at 0.
- Step value 0 means instantaneous segment; it never stalls.
- Latency: level change is visible one Clk after the qualifying sample_tick. State change is visible one Clk after the strobe.
- env_active is derived from the registered state in the same cycle; no extra lag.

Optional Feature:
HARD_RETRIG_EN:
- Defined: an accepted noteTrig also forces env_level<=0 in the same edge. Every attack then starts from silence.
- Undefined: level is preserved across retrigger, as above.
- Both builds: env_done is never asserted by a retrigger.

Test Plan:
- Reset, then noteTrig with noteIdx=42, atk_step=0x4000, ticks every 4 clocks -> note_idx_out=42; level 0x4000, 0x8000, 0xC000, then 0xFFFF with state DECAY on 4th tick.
- Continue with dec_step=0x1000, sus_lvl=0xC000 -> level 0xEFFF, 0xDFFF, 0xCFFF, then 0xC000/SUSTAIN; change sus_lvl to 0x8000 -> level 0x8000 on next tick.
- noteOff in SUSTAIN at 0x8000, rel_step=0x3000 -> 0x5000, 0x2000, then 0 with IDLE and exactly one env_done pulse; env_active falls the same cycle.
- noteTrig in RELEASE at level 0x5000 -> state ATTACK and level stays 0x5000 (0 with HARD_RETRIG_EN); no env_done.
- noteTrig and noteOff asserted together, and sample_tick coincident with noteTrig -> state ATTACK, no level step that cycle.
- atk_step=dec_step=rel_step=0 -> ENV_MAX on first tick, sus_lvl on second, 0 and IDLE on the first tick after noteOff; Reset asserted mid-DECAY -> all outputs at reset values next cycle.
